// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall sequencer.
// Latency: none, plain wires. Backpressure: the sequencer's enables are the stall mechanism.
// Ports: master = pipeline side (drives hazard sources, receives enables/flushes);
//        slave  = hazard controller (samples hazard sources, drives enables/flushes/stall_cnt).
// REG_ADDR_W and CNT_W must match the parameters of the pipeline_hazard_ctrl instance.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    // hazard sources
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  branch_taken;
    logic                  mem_busy;
    // pipeline controls
    logic                  pc_write;
    logic                  if_id_write;
    logic                  pipe_en;
    logic                  ctrl_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_mem_read, ex_rd, branch_taken, mem_busy,
        input  pc_write, if_id_write, pipe_en, ctrl_en,
        input  if_id_flush, id_ex_flush, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_mem_read, ex_rd, branch_taken, mem_busy,
        output pc_write, if_id_write, pipe_en, ctrl_en,
        output if_id_flush, id_ex_flush, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: load-use bubbles, branch flushes, dmem freeze.
// Latency: Mealy outputs, hazard inputs act in the same cycle; state changes land next cycle.
// Backpressure: mem_busy freezes every stage (state held); load-use holds PC and IF/ID only.
// Ports: clk, rst (sync, active-high); hz (slave modport) carries ID/EX register fields,
//        branch_taken, mem_busy in, and pc_write, if_id_write, pipe_en, ctrl_en,
//        if_id_flush, id_ex_flush, stall_cnt out.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    // cnt only has to cover the longer of the two multi-cycle sequences
    localparam int SEQ_MAX = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX + 1) : 1;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [SEQ_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;

    logic pc_write, if_id_write, pipe_en, ctrl_en, if_id_flush, id_ex_flush;

    // x0 is hard-wired zero, so a load targeting it can never create a dependency
    assign load_use = hz.ex_mem_read && (hz.ex_rd != ZERO_REG) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        pipe_en     = 1'b1;
        ctrl_en     = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            ctrl_en     = 1'b0;
            state_nxt   = RUN;
            cnt_nxt     = '0;
        end else if (hz.mem_busy) begin
            // full freeze; branch/load-use are re-presented once memory is ready
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
        end else if (hz.branch_taken && (state != FLUSH)) begin
            // a branch in FLUSH comes from a wrong-path instruction and is dropped
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = SEQ_W'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ctrl_en     = 1'b0;
                        if (LOAD_LAT > 1) begin
                            state_nxt = LOAD_STALL;
                            cnt_nxt   = SEQ_W'(LOAD_LAT - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    // remaining bubbles are unconditional; the load is already in flight
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ctrl_en     = 1'b0;
                    if (cnt == SEQ_W'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - SEQ_W'(1);
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    if (cnt == SEQ_W'(1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - SEQ_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // cycles lost to stalls/freezes; saturating so long runs stay meaningful
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.pipe_en     = pipe_en;
    assign hz.ctrl_en     = ctrl_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances share stimulus.
// Instance a: LOAD_LAT=1, FLUSH_CYCLES=1, CNT_W=16. Instance b: LOAD_LAT=3, FLUSH_CYCLES=2, CNT_W=4.
// Observed vector per instance: {pc_write, if_id_write, pipe_en, ctrl_en, if_id_flush, id_ex_flush, stall_cnt[15:0]}.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if_a ();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  if_b ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .hz(if_a.slave));
    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .hz(if_b.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: outstanding extra bubbles / flush cycles and the stall count
    int bub_left [2] = '{0, 0};
    int fl_left  [2] = '{0, 0};
    int scnt     [2] = '{0, 0};
    int cfg_ll   [2] = '{1, 3};
    int cfg_fc   [2] = '{1, 2};
    int cfg_smax [2] = '{65535, 15};

    logic [21:0] oa, ea, ob, eb;

    // One clock cycle: apply inputs, predict, sample mid-cycle, advance the model.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic mr, input logic [4:0] rd, input logic bt, input logic mb,
                       input logic r, output logic [21:0] obs_a, output logic [21:0] exp_a,
                       output logic [21:0] obs_b, output logic [21:0] exp_b);
        logic       lu;
        logic [5:0] o [2];
        @(posedge clk);
        #1;
        rst = r;
        if_a.id_rs1 = rs1; if_a.id_rs2 = rs2; if_a.id_uses_rs1 = u1; if_a.id_uses_rs2 = u2;
        if_a.ex_mem_read = mr; if_a.ex_rd = rd; if_a.branch_taken = bt; if_a.mem_busy = mb;
        if_b.id_rs1 = rs1; if_b.id_rs2 = rs2; if_b.id_uses_rs1 = u1; if_b.id_uses_rs2 = u2;
        if_b.ex_mem_read = mr; if_b.ex_rd = rd; if_b.branch_taken = bt; if_b.mem_busy = mb;
        lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 2; k++) begin
            if (r)                  o[k] = 6'b000000;
            else if (mb)            o[k] = 6'b000100;
            else if (fl_left[k] > 0) o[k] = 6'b111110;
            else if (bt)            o[k] = 6'b111111;
            else if (bub_left[k] > 0 || lu) o[k] = 6'b001000;
            else                    o[k] = 6'b111100;
        end
        exp_a = {o[0], 16'(scnt[0])};
        exp_b = {o[1], 16'(scnt[1])};
        @(negedge clk);
        obs_a = {if_a.pc_write, if_a.if_id_write, if_a.pipe_en, if_a.ctrl_en,
                 if_a.if_id_flush, if_a.id_ex_flush, 16'(if_a.stall_cnt)};
        obs_b = {if_b.pc_write, if_b.if_id_write, if_b.pipe_en, if_b.ctrl_en,
                 if_b.if_id_flush, if_b.id_ex_flush, 16'(if_b.stall_cnt)};
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                bub_left[k] = 0; fl_left[k] = 0; scnt[k] = 0;
            end else if (!mb) begin
                if (fl_left[k] > 0) fl_left[k]--;
                else if (bt) begin bub_left[k] = 0; fl_left[k] = cfg_fc[k] - 1; end
                else if (bub_left[k] > 0) bub_left[k]--;
                else if (lu) bub_left[k] = cfg_ll[k] - 1;
            end
            if (!r && !o[k][5] && scnt[k] < cfg_smax[k]) scnt[k]++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(5'd5, 5'd6, 1, 1, 1, 5'd5, (i == 1), (i == 2), 1, oa, ea, ob, eb);
            n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL reset_a got %h exp %h", oa, ea); end
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL reset_b got %h exp %h", ob, eb); end
        end
    endtask

    task automatic test_load_use();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, oa, ea, ob, eb);
        cyc(5'd5, 5'd2, 1, 0, 1, 5'd5, 0, 0, 0, oa, ea, ob, eb);
        n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL lu_first_a got %h exp %h", oa, ea); end
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL lu_first_b got %h exp %h", ob, eb); end
        for (int i = 0; i < 4; i++) begin
            cyc(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1, 0, 5'($urandom_range(0, 31)),
                0, 0, 0, oa, ea, ob, eb);
            n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL lu_tail_a got %h exp %h", oa, ea); end
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL lu_tail_b got %h exp %h", ob, eb); end
        end
        n_tests++; if (oa[15:0] !== 16'd1) begin n_fail++; $display("FAIL lu_count_a got %0d exp 1", oa[15:0]); end
        n_tests++; if (ob[15:0] !== 16'd3) begin n_fail++; $display("FAIL lu_count_b got %0d exp 3", ob[15:0]); end
        // load to x0 never stalls
        cyc(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, oa, ea, ob, eb);
        n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL lu_x0_a got %h exp %h", oa, ea); end
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL lu_x0_b got %h exp %h", ob, eb); end
        cyc(5'd3, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0, oa, ea, ob, eb);
        n_tests++; if (ob[21:16] !== 6'b001000) begin n_fail++; $display("FAIL lu_rs2_b got %b exp 001000", ob[21:16]); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, oa, ea, ob, eb);
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL lu_rs2_tail_b got %h exp %h", ob, eb); end
        end
    endtask

    task automatic test_branch();
        logic bts [4] = '{1, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, bts[i], 0, 0, oa, ea, ob, eb);
            n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL branch_a[%0d] got %h exp %h", i, oa, ea); end
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL branch_b[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    task automatic test_mem_busy();
        logic [15:0] base_b;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, oa, ea, ob, eb);
        for (int i = 0; i < 8; i++) begin
            cyc(5'd7, 5'd0, 1, 0, (i == 0), 5'd7, 0, (i >= 1 && i <= 4), 0, oa, ea, ob, eb);
            if (i == 0) base_b = ob[15:0];
            n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL membusy_a[%0d] got %h exp %h", i, oa, ea); end
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL membusy_b[%0d] got %h exp %h", i, ob, eb); end
        end
        n_tests++; if (ob[15:0] - base_b !== 16'd7) begin n_fail++; $display("FAIL membusy_total_b got %0d exp 7", ob[15:0] - base_b); end
    endtask

    task automatic test_simultaneous();
        cyc(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, oa, ea, ob, eb);
        n_tests++; if (oa[21:16] !== 6'b111111) begin n_fail++; $display("FAIL br_lu_a got %b exp 111111", oa[21:16]); end
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL br_lu_b got %h exp %h", ob, eb); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, oa, ea, ob, eb);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, oa, ea, ob, eb);
        n_tests++; if (oa[21:16] !== 6'b000100) begin n_fail++; $display("FAIL mb_br_a got %b exp 000100", oa[21:16]); end
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL mb_br_b got %h exp %h", ob, eb); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, oa, ea, ob, eb);
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL mb_br_after_b got %h exp %h", ob, eb); end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, oa, ea, ob, eb);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, oa, ea, ob, eb);
        n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL rst_in_flush_b got %h exp %h", ob, eb); end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, oa, ea, ob, eb);
        n_tests++; if (ob !== {6'b111100, 16'd0}) begin n_fail++; $display("FAIL rst_release_b got %h exp 3c0000", ob); end
        for (int i = 0; i < 21; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, (i < 20), 0, oa, ea, ob, eb);
        end
        n_tests++; if (ob[15:0] !== 16'd15) begin n_fail++; $display("FAIL sat_b got %0d exp 15", ob[15:0]); end
        n_tests++; if (oa[15:0] !== 16'd20) begin n_fail++; $display("FAIL sat_a got %0d exp 20", oa[15:0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 49) == 0), oa, ea, ob, eb);
            n_tests++; if (oa !== ea) begin n_fail++; $display("FAIL random_a[%0d] got %h exp %h", i, oa, ea); end
            n_tests++; if (ob !== eb) begin n_fail++; $display("FAIL random_b[%0d] got %h exp %h", i, ob, eb); end
        end
    endtask

    initial begin
        if_a.id_rs1 = 0; if_a.id_rs2 = 0; if_a.id_uses_rs1 = 0; if_a.id_uses_rs2 = 0;
        if_a.ex_mem_read = 0; if_a.ex_rd = 0; if_a.branch_taken = 0; if_a.mem_busy = 0;
        if_b.id_rs1 = 0; if_b.id_rs2 = 0; if_b.id_uses_rs1 = 0; if_b.id_uses_rs2 = 0;
        if_b.ex_mem_read = 0; if_b.ex_rd = 0; if_b.branch_taken = 0; if_b.mem_busy = 0;
        rst = 1'b1;
        @(posedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall sequencer for the 5-stage pipeline. Detects load-use hazards, taken-branch redirects and data-memory wait states. Drives the PC and IF/ID write enables, the pipeline-register enable, and the flush strobes. Generates ctrl_en, which is the select of the ID-stage control-gating mux (1 passes control signals, 0 injects a bubble).

Parameters:
REG_ADDR_W, 5, register-address width.
LOAD_LAT, 1, bubble cycles per load-use hazard; must be >= 1.
FLUSH_CYCLES, 1, cycles of IF/ID flush per taken branch; must be >= 1.
CNT_W, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
id_rs1  in  REG_ADDR_W  ID-stage source register 1
id_rs2  in  REG_ADDR_W  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  EX-stage instruction is a load
ex_rd  in  REG_ADDR_W  EX-stage destination register
branch_taken  in  1  branch resolved taken this cycle
mem_busy  in  1  data memory not ready; freeze the pipeline
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
pipe_en  out  1  ID/EX, EX/MEM and MEM/WB register enable
ctrl_en  out  1  control-gating mux select (0 = bubble)
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to NOP
stall_cnt  out  CNT_W  count of cycles with pc_write=0

Behaviour:
- Reset and clocking:
  - One clock, rst synchronous active-high. Reset is sampled on the rising edge.
  - While rst=1 the outputs are forced: pc_write=0, if_id_write=0, pipe_en=0, ctrl_en=0, if_id_flush=0, id_ex_flush=0.
  - On the reset edge: state <= RUN, cnt <= 0, stall_cnt <= 0.
  - Reset mid-stall or mid-flush aborts immediately. There is no residual bubble after reset is released.
- Hazard term (combinational):
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Outputs are Mealy: a function of state, cnt and the current inputs.
- Default (pass) outputs: pc_write=1, if_id_write=1, pipe_en=1, ctrl_en=1, both flushes=0.
- Event priority, evaluated in every state: mem_busy > branch_taken > state action.
- mem_busy=1:
  - Outputs: pc_write=0, if_id_write=0, pipe_en=0, ctrl_en=1, flushes=0.
  - state and cnt hold. branch_taken and load_use are ignored that cycle.
- State RUN:
  - On branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1 (target load).
    - If FLUSH_CYCLES>1: next=FLUSH, cnt<=FLUSH_CYCLES-1. Otherwise remain in RUN.
  - Else on load_use: pc_write=0, if_id_write=0, ctrl_en=0, pipe_en=1.
    - If LOAD_LAT>1: next=LOAD_STALL, cnt<=LOAD_LAT-1. Otherwise remain in RUN.
  - Else: pass outputs.
- State LOAD_STALL:
  - Outputs as for a load-use bubble. cnt decrements.
  - When cnt==1 at the edge: next=RUN.
  - branch_taken here aborts the stall and behaves exactly as branch_taken in RUN.
- State FLUSH:
  - Outputs: if_id_flush=1, pc_write=1, if_id_write=1, ctrl_en=1, pipe_en=1, id_ex_flush=0. cnt decrements.
  - When cnt==1: next=RUN.
  - branch_taken is ignored (wrong-path instruction).
- stall_cnt:
  - Increments by 1 on each non-reset edge where pc_write=0.
  - Saturates at 2^CNT_W-1; no wrap.
- No latency beyond the combinational path: hazard inputs affect outputs in the same cycle. State updates take effect in the next cycle.
- An ex_rd==0 load never stalls.
- Simultaneous mem_busy and branch_taken: freeze only. The branch must be re-presented by the pipeline once mem_busy drops.

Test Plan:
1. Load-use hazard, LOAD_LAT=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> that cycle pc_write=0, if_id_write=0, ctrl_en=0; next cycle all 1; stall_cnt=1.
2. LOAD_LAT=3, same hazard -> exactly 3 consecutive bubble cycles (ctrl_en=0) regardless of inputs after the first; stall_cnt=3; x0 case (ex_rd=0) -> no stall.
3. Branch with FLUSH_CYCLES=2: branch_taken=1 for one cycle -> cycle0 if_id_flush=1, id_ex_flush=1; cycle1 if_id_flush=1, id_ex_flush=0; cycle2 pass; a branch_taken in cycle1 causes no extension.
4. mem_busy=1 for 4 cycles during LOAD_STALL (LOAD_LAT=3, cnt=2) -> 4 frozen cycles (pipe_en=0); the stall then resumes with 2 remaining bubble cycles; stall_cnt increases by 7 in total (1 RUN bubble + 4 frozen + 2 resumed).
5. Simultaneous branch_taken and load_use in RUN -> flush outputs only, ctrl_en=1; mem_busy plus branch_taken -> freeze, no flush.
6. rst=1 asserted during FLUSH -> same cycle all enables 0; after release state RUN, pass outputs, stall_cnt=0; with CNT_W=4 and 20 stall cycles, stall_cnt stays at 15.
